// File: rtl/mem_arb_pkg.sv
// Shared encodings and constants for the two-requester memory arbiter.
// Also holds the alignment/range check applied to a latched request.
package mem_arb_pkg;

  localparam int ARB_DEPTH = 32;
  // Width of the word index taken from addr[31:2].
  localparam int WORD_AW = 30;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  // True when the byte address is misaligned or its word index is past the memory.
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
    logic [WORD_AW-1:0] word;
    word = addr[31:2];
    return (addr[1:0] != 2'b00) || ({{(32-WORD_AW){1'b0}}, word} >= depth);
  endfunction

endpackage

// File: rtl/_mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// On a tie between eligible requests, the requester other than last wins.
module _rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic elig0,
  input  logic elig1,
  input  logic last,
  output logic valid,
  output logic sel
);

  logic cand0;
  logic cand1;

  always_comb begin
    cand0 = req0 & elig0;
    cand1 = req1 & elig1;
    valid = cand0 | cand1;
    if (cand0 && cand1) begin
      sel = ~last;
    end else begin
      sel = cand1;
    end
  end

endmodule

// File: rtl/_mem_arbiter.sv
// Round-robin arbiter and single-access sequencer in front of the data memory.
// Handshake: a requester holds req until it sees its one-cycle gnt; done/err/rdata follow one edge later.
module _mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = ARB_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output arb_state_t  dbg_state
);

  arb_state_t  state_q, state_d;
  owner_t      owner_q, owner_d;
  owner_t      last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        elig0;
  logic        elig1;
  logic        pick_valid;
  logic        pick_sel;
  logic        acc_err;
  logic        in_access;

  assign in_access = (state_q == ST_ACCESS);
  assign acc_err   = addr_err(addr_q, 32'(DEPTH));
  assign dbg_state = state_q;

  // The owner's request is stale during its own access cycle, so it sits out that edge.
  assign elig0 = !(in_access && (owner_q == OWN_M0));
  assign elig1 = !(in_access && (owner_q == OWN_M1));

  _rr_pick2 u_pick (
    .req0  (m0_req),
    .req1  (m1_req),
    .elig0 (elig0),
    .elig1 (elig1),
    .last  (last_q == OWN_M1),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_M0;
      last_q  <= OWN_M1;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (pick_valid) begin
      state_d = ST_ACCESS;
      owner_d = owner_t'(pick_sel);
      last_d  = owner_t'(pick_sel);
      if (pick_sel) begin
        we_d    = m1_we;
        addr_d  = m1_addr;
        wdata_d = m1_wdata;
      end else begin
        we_d    = m0_we;
        addr_d  = m0_addr;
        wdata_d = m0_wdata;
      end
    end
  end

  // Memory strobes come only from state and latched fields.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    if (in_access) begin
      mem_read  = !we_q && !acc_err;
      mem_write = we_q && !acc_err;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      m0_gnt    = (owner_q == OWN_M0);
      m1_gnt    = (owner_q == OWN_M1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      m0_rdata <= 32'h0;
      m1_rdata <= 32'h0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;
      if (in_access) begin
        if (owner_q == OWN_M0) begin
          m0_done <= 1'b1;
          m0_err  <= acc_err;
          if (acc_err) begin
            m0_rdata <= 32'h0;
          end else if (!we_q) begin
            m0_rdata <= mem_rdata;
          end
        end else begin
          m1_done <= 1'b1;
          m1_err  <= acc_err;
          if (acc_err) begin
            m1_rdata <= 32'h0;
          end else if (!we_q) begin
            m1_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb__mem_arbiter.sv
// Directed bench for _mem_arbiter with a behavioural 32-word memory attached.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb__mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic        m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt;
  logic        m0_done, m1_done;
  logic        m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  arb_state_t  dbg_state;

  logic [31:0] mem_model [0:31];
  logic [31:0] exp_q[$];
  int          n_tests;
  int          n_fail;

  _mem_arbiter #(.DEPTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_done   (m0_done),
    .m1_done   (m1_done),
    .m0_err    (m0_err),
    .m1_err    (m1_err),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // attached memory: combinational read, write commits on the rising edge
  assign mem_rdata = mem_model[mem_addr[6:2]];
  always @(posedge clk) begin
    if (mem_write) mem_model[mem_addr[6:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_req(input int m, input logic r, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = r; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = r; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full access from a lone requester; called from a falling edge with the arbiter idle.
  task automatic run_access(input int m, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic exp_err,
                            input logic [31:0] exp_rd);
    int   waited;
    logic seen;
    drive_req(m, 1'b1, we, addr, wdata);
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 8) begin
      @(negedge clk);
      waited++;
      seen = (m == 0) ? m0_gnt : m1_gnt;
    end
    check("gnt_latency", waited, 1);
    check("mem_read", mem_read, !we && !exp_err);
    check("mem_write", mem_write, we && !exp_err);
    check("mem_addr", mem_addr, addr);
    if (we && !exp_err) check("mem_wdata", mem_wdata, wdata);
    drive_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("done", (m == 0) ? m0_done : m1_done, 1);
    check("err", (m == 0) ? m0_err : m1_err, exp_err);
    check("rdata", (m == 0) ? m0_rdata : m1_rdata, exp_rd);
    check("gnt_after_done", (m == 0) ? m0_gnt : m1_gnt, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) mem_model[i] <= 32'hA000_0000 + i;

    // reset with random request traffic
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_req(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      drive_req(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    @(negedge clk);
    check("rst_ctrl", {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, mem_read, mem_write}, 0);
    check("rst_rdata0", m0_rdata, 0);
    check("rst_rdata1", m1_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_state", dbg_state, ST_IDLE);
    check("idle_strobes", {mem_read, mem_write, m0_gnt, m1_gnt}, 0);

    // m1 writes, m0 reads it back
    run_access(1, 1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0, 32'h0);
    run_access(0, 1'b0, 32'h08, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // contention from a fresh reset: m0 wins first, then strict alternation
    apply_reset();
    drive_req(0, 1'b1, 1'b0, 32'h00, 32'h0);
    drive_req(1, 1'b1, 1'b0, 32'h04, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("cont_gnt0", m0_gnt, (k % 2) == 0);
      check("cont_gnt1", m1_gnt, (k % 2) == 1);
      if (k > 0) begin
        check("cont_done", ((k - 1) % 2 == 0) ? m0_done : m1_done, 1);
        check("cont_rdata", ((k - 1) % 2 == 0) ? m0_rdata : m1_rdata, exp_q.pop_front());
      end
      exp_q.push_back(((k % 2) == 0) ? 32'hA000_0000 : 32'hA000_0001);
    end
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("cont_last_done", m1_done, 1);
    check("cont_last_rdata", m1_rdata, exp_q.pop_front());
    check("cont_idle", {m0_gnt, m1_gnt, m0_done}, 0);
    check("cont_q_empty", exp_q.size(), 0);

    // misaligned write is suppressed, word 1 keeps its value
    run_access(0, 1'b1, 32'h06, 32'h55, 1'b1, 32'h0);
    run_access(1, 1'b0, 32'h04, 32'h0, 1'b0, 32'hA000_0001);

    // out-of-range read: word 32 with a 32-word memory
    run_access(1, 1'b0, 32'h80, 32'h0, 1'b1, 32'h0);

    // reset lands in the middle of a write
    drive_req(0, 1'b1, 1'b1, 32'h10, 32'h1234);
    @(negedge clk);
    check("mid_gnt", m0_gnt, 1);
    check("mid_write_on", mem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_write_drop", mem_write, 0);
    check("mid_state", dbg_state, ST_IDLE);
    drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("mid_no_done", m0_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_access(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hA000_0004);

    // a lone requester holding req is granted every other cycle
    drive_req(0, 1'b1, 1'b0, 32'h08, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("solo_gnt", m0_gnt, (k % 2) == 0);
      check("solo_done", m0_done, (k % 2) == 1);
      if (k == 3) drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    check("solo_rdata", m0_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("solo_idle", {m0_gnt, m0_done, mem_read}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
